// File: rtl/conv1_xnor_pe.sv
// XNOR-popcount binary convolution over 3x3 windows for conv1: per-filter match count,
// thresholded activation, output-pixel coordinates and end-of-frame pulse for pooling.
module conv1_xnor_pe #(
  parameter int unsigned WIDTH       = 28,
  parameter int unsigned HEIGHT      = 28,
  parameter int unsigned NUM_FILTERS = 4,
  localparam int unsigned AW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
  localparam int unsigned XW = (WIDTH - 2 > 1) ? $clog2(WIDTH - 2) : 1,
  localparam int unsigned YW = (HEIGHT - 2 > 1) ? $clog2(HEIGHT - 2) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  input  logic                       pixel_0,
  input  logic                       pixel_1,
  input  logic                       pixel_2,
  input  logic                       pixel_3,
  input  logic                       pixel_4,
  input  logic                       pixel_5,
  input  logic                       pixel_6,
  input  logic                       pixel_7,
  input  logic                       pixel_8,
  input  logic                       w_we,
  input  logic [AW-1:0]              w_addr,
  input  logic [8:0]                 w_data,
  input  logic [3:0]                 t_data,
  output logic                       valid_out,
  output logic [NUM_FILTERS-1:0]     act_out,
  output logic [4*NUM_FILTERS-1:0]   sum_out,
  output logic [XW-1:0]              out_x,
  output logic [YW-1:0]              out_y,
  output logic                       frame_done
);

  function automatic logic [3:0] popcnt9(input logic [8:0] v);
    logic [3:0] c;
    c = '0;
    for (int k = 0; k < 9; k++) c = c + {3'b000, v[k]};
    return c;
  endfunction

  logic [8:0] window;
  logic [8:0] kernel_q [NUM_FILTERS];
  logic [3:0] thresh_q [NUM_FILTERS];
  logic [3:0] match_d  [NUM_FILTERS];
  logic [3:0] match_q  [NUM_FILTERS];
  logic       v1_q;

  logic [NUM_FILTERS-1:0]   act_d, act_q;
  logic [4*NUM_FILTERS-1:0] sum_d, sum_q;
  logic                     valid_q;
  logic [XW-1:0]            x_d, x_q;
  logic [YW-1:0]            y_d, y_q;
  logic                     last_x, last_y;

  assign window = {pixel_8, pixel_7, pixel_6, pixel_5, pixel_4,
                   pixel_3, pixel_2, pixel_1, pixel_0};

  always_comb begin
    for (int f = 0; f < NUM_FILTERS; f++) begin
      match_d[f] = popcnt9(~(window ^ kernel_q[f]));
    end
  end

  // Writes land on the same edge that captures a window, so that window sees the old kernel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < NUM_FILTERS; f++) begin
        kernel_q[f] <= 9'h1FF;
        thresh_q[f] <= 4'd5;
      end
    end else begin
      for (int f = 0; f < NUM_FILTERS; f++) begin
        if (w_we && (w_addr == AW'(f))) begin
          kernel_q[f] <= w_data;
          thresh_q[f] <= t_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      for (int f = 0; f < NUM_FILTERS; f++) match_q[f] <= '0;
    end else begin
      v1_q <= valid_in;
      for (int f = 0; f < NUM_FILTERS; f++) match_q[f] <= match_d[f];
    end
  end

  // Threshold is read here, so it reflects any write that landed on the stage-1 edge.
  always_comb begin
    sum_d = '0;
    act_d = '0;
    if (v1_q) begin
      for (int f = 0; f < NUM_FILTERS; f++) begin
        sum_d[4*f +: 4] = match_q[f];
        act_d[f]        = (match_q[f] >= thresh_q[f]);
      end
    end
  end

  assign last_x = (x_q == XW'(WIDTH - 3));
  assign last_y = (y_q == YW'(HEIGHT - 3));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (valid_q) begin
      if (last_x) begin
        x_d = '0;
        y_d = last_y ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      act_q   <= '0;
      sum_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      valid_q <= v1_q;
      act_q   <= act_d;
      sum_q   <= sum_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign valid_out  = valid_q;
  assign act_out    = act_q;
  assign sum_out    = sum_q;
  assign out_x      = x_q;
  assign out_y      = y_q;
  assign frame_done = valid_q && last_x && last_y;

endmodule

// File: doc/conv1_xnor_pe.md
Name: conv1_xnor_pe

Overview:
- Binary convolution engine directly downstream of the 3x3 window line buffer in the conv1 layer.
- Each valid 3x3 binary window is applied to NUM_FILTERS binary kernels using XNOR-popcount. Each filter produces a 4-bit match count and a thresholded 1-bit activation.
- Output-pixel coordinates and an end-of-frame pulse are tracked for the pooling stage downstream.
- Kernels and thresholds are runtime-writable through a simple register write port.

Parameters:
- WIDTH, 28, input image width in pixels.
- HEIGHT, 28, input image height in pixels.
- NUM_FILTERS, 4, number of binary 3x3 kernels evaluated in parallel.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- valid_in  input  1  window valid; one window per asserted cycle, no backpressure
- pixel_0..pixel_8  input  1 each  window bits, row-major: pixel_0 is top-left, pixel_8 is bottom-right
- w_we  input  1  weight/threshold write strobe
- w_addr  input  clog2(NUM_FILTERS) (min 1)  filter index
- w_data  input  9  kernel bits; bit k pairs with pixel_k
- t_data  input  4  activation threshold, 0..9
- valid_out  output  1  result valid
- act_out  output  NUM_FILTERS  bit f = (match_f >= thresh_f)
- sum_out  output  4*NUM_FILTERS  match_f at [4f+3:4f], range 0..9
- out_x  output  clog2(WIDTH-2)  column of current output, 0..WIDTH-3
- out_y  output  clog2(HEIGHT-2)  row of current output, 0..HEIGHT-3
- frame_done  output  1  one-cycle pulse coincident with the last output of a frame

Behaviour:
- Reset (asynchronous):
  - valid_out=0, act_out=0, sum_out=0, out_x=0, out_y=0, frame_done=0.
  - All kernels = 9'h1FF; all thresholds = 5.
  - Pipeline valid bits cleared.
- Pipeline stage 1 (cycle after valid_in=1):
  - Register window bits.
  - Register per-filter match_f = popcount(~(window ^ kernel_f)), 4 bits, unsigned.
  - Stage-1 valid = valid_in.
- Pipeline stage 2, the output register:
  - valid_out = stage-1 valid.
  - sum_out = match values.
  - act_out[f] = (match_f >= thresh_f), unsigned compare.
  - When stage-1 valid=0: valid_out=0 and act_out, sum_out driven to 0.
- Latency: fixed 2 cycles from valid_in to valid_out. Back-to-back windows give back-to-back results; bubbles propagate unchanged.
- Coordinates:
  - out_x/out_y show the position of the result currently on the outputs.
  - The internal counter advances after each valid_out beat.
  - out_x wraps at WIDTH-3 to 0 and increments out_y.
  - out_y wraps at HEIGHT-3 to 0.
  - Expected beats per frame = (WIDTH-2)*(HEIGHT-2), 676 at defaults.
- frame_done=1 only in a valid_out cycle where out_x=WIDTH-3 and out_y=HEIGHT-3. The counter then returns to (0,0).
- Weight writes:
  - On w_we=1 with w_addr < NUM_FILTERS, kernel[w_addr]<=w_data and thresh[w_addr]<=t_data at the clock edge.
  - w_addr >= NUM_FILTERS: write ignored.
  - t_data > 9: stored as-is; that filter's act is then always 0.
- Simultaneous write and valid_in: the window captured that edge uses the pre-write kernel. The new kernel applies from the next valid_in onward. Threshold compare in stage 2 uses the threshold value present at the stage-2 edge.
- Reset mid-frame: in-flight results are discarded, coordinates return to (0,0), weights revert to defaults. The next valid window is treated as output (0,0).
- No internal stall: valid_in may assert every cycle indefinitely.

Test Plan:
- Reset, defaults, window all ones, one valid_in -> two cycles later valid_out=1, every sum field=9, act_out=4'hF, out_x=0, out_y=0.
- Write filter 1 with w_data=9'h0AA, t_data=9; apply window 9'h0AA (pixel_k = bit k) -> sum1=9, act[1]=1; window 9'h155 -> sum1=0, act[1]=0; filters 0,2,3 (kernel 1FF, thresh 5): sum=4 act=0 for 0AA, sum=5 act=1 for 155.
- Stream 676 consecutive valid windows, including 3 single-cycle gaps -> exactly 676 valid_out beats; coordinates step (0,0)..(25,0),(0,1)...; frame_done a single pulse at (25,25); next beat at (0,0).
- w_we for filter 0 (w_data=0, t_data=0) in the same cycle as valid_in with all-ones window -> that result sum0=9; next window gives sum0=0, act[0]=1.
- w_addr=4 (out of range, NUM_FILTERS=4) -> no filter changes; t_data=10 on filter 2 -> act[2]=0 even for sum2=9.
- Assert rst_n low for 1 cycle after 300 outputs with stage 1 full -> no valid_out for the flushed beat; next result reports (0,0) with default weights.
